// File: rtl/fnd_scan_decoder_if.sv
// fnd_scan_decoder_if: multiplexed 7-segment bus plus decoded frame results
interface fnd_scan_decoder_if;
  logic [7:0]  seg;
  logic [3:0]  seg_comm;
  logic [3:0]  digit_1;
  logic [3:0]  digit_10;
  logic [3:0]  digit_100;
  logic [3:0]  digit_1000;
  logic [3:0]  dp;
  logic [13:0] value;
  logic        frame_done;
  logic        active;
  logic        pattern_err;
  logic        bcd_err;
  modport master (
    output seg, seg_comm,
    input  digit_1, digit_10, digit_100, digit_1000, dp, value,
    input  frame_done, active, pattern_err, bcd_err
  );
  modport slave (
    input  seg, seg_comm,
    output digit_1, digit_10, digit_100, digit_1000, dp, value,
    output frame_done, active, pattern_err, bcd_err
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: filters a scanned 7-segment bus and rebuilds 4-digit frames
module fnd_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2_000_000
) (
  input logic clk,
  input logic reset,
  fnd_scan_decoder_if.slave bus
);
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0][6:0] HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  typedef enum logic [1:0] {COLLECT, CHECK, CALC} state_t;
  state_t           state_q, state_d;
  logic [11:0]      prev_q, prev_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic             sampled_q, sampled_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  sh_q, sh_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             pub_q, pub_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       dp_q, dp_d;
  logic [13:0]      value_q, value_d;
  logic             frame_done_q, frame_done_d;
  logic             active_q, active_d;
  logic             pattern_err_q, pattern_err_d;
  logic             bcd_err_q, bcd_err_d;
  logic [11:0]      cur;
  logic             changed, take, blank, comm_ok, hit, legal, tmo_hit, bcd_ok;
  logic [3:0]       code;
  logic [1:0]       pos;
  assign cur     = {bus.seg, bus.seg_comm};
  assign changed = cur != prev_q;
  assign take    = !changed && stab_q == SW'(STABLE_CYCLES - 1) && !sampled_q;
  assign blank   = bus.seg_comm == 4'hF;
  assign comm_ok = $onehot(~bus.seg_comm);
  assign pos     = !bus.seg_comm[0] ? 2'd0 : !bus.seg_comm[1] ? 2'd1 : !bus.seg_comm[2] ? 2'd2 : 2'd3;
  assign legal   = take && comm_ok && hit;
  assign tmo_hit = !legal && tmo_q == TW'(TIMEOUT - 1);
  assign bcd_ok  = sh_q[0] <= 4'd9 && sh_q[1] <= 4'd9 && sh_q[2] <= 4'd9 && sh_q[3] <= 4'd9;
  always_comb begin
    hit  = 1'b0;
    code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (bus.seg[6:0] == HEX[i]) begin
        hit  = 1'b1;
        code = 4'(i);
      end
  end
  always_comb begin
    prev_d        = cur;
    stab_d        = changed ? '0 : (stab_q == SW'(STABLE_CYCLES - 1) ? stab_q : stab_q + SW'(1));
    sampled_d     = !changed && (sampled_q || take);
    tmo_d         = legal ? '0 : tmo_hit ? tmo_q : tmo_q + TW'(1);
    sh_d          = sh_q;
    sh_dp_d       = sh_dp_q;
    if (legal) begin
      sh_d[pos]    = code;
      sh_dp_d[pos] = ~bus.seg[7];
    end
    mask_d        = tmo_hit ? 4'b0 : mask_q | (legal ? 4'b0001 << pos : 4'b0);
    pattern_err_d = take && !blank && !(comm_ok && hit);
    state_d       = state_q;
    pub_d         = pub_q;
    dig_d         = dig_q;
    dp_d          = dp_q;
    value_d       = value_q;
    bcd_err_d     = 1'b0;
    frame_done_d  = 1'b0;
    active_d      = active_q && !tmo_hit;
    case (state_q)
      COLLECT: if (mask_d == 4'hF) begin
        state_d = CHECK;
        mask_d  = 4'b0;
      end
      CHECK: begin
        pub_d     = bcd_ok;
        dig_d     = bcd_ok ? sh_q : dig_q;
        dp_d      = bcd_ok ? sh_dp_q : dp_q;
        bcd_err_d = !bcd_ok;
        state_d   = CALC;
      end
      CALC: begin
        value_d      = pub_q ? 14'(dig_q[3]) * 14'd1000 + 14'(dig_q[2]) * 14'd100
                             + 14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]) : value_q;
        frame_done_d = pub_q;
        active_d     = pub_q || active_d;
        state_d      = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= COLLECT;
      prev_q        <= '0;
      stab_q        <= '0;
      sampled_q     <= 1'b0;
      tmo_q         <= '0;
      mask_q        <= '0;
      sh_q          <= '0;
      sh_dp_q       <= '0;
      pub_q         <= 1'b0;
      dig_q         <= '0;
      dp_q          <= '0;
      value_q       <= '0;
      frame_done_q  <= 1'b0;
      active_q      <= 1'b0;
      pattern_err_q <= 1'b0;
      bcd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      sampled_q     <= sampled_d;
      tmo_q         <= tmo_d;
      mask_q        <= mask_d;
      sh_q          <= sh_d;
      sh_dp_q       <= sh_dp_d;
      pub_q         <= pub_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
      value_q       <= value_d;
      frame_done_q  <= frame_done_d;
      active_q      <= active_d;
      pattern_err_q <= pattern_err_d;
      bcd_err_q     <= bcd_err_d;
    end
  end
  assign bus.digit_1     = dig_q[0];
  assign bus.digit_10    = dig_q[1];
  assign bus.digit_100   = dig_q[2];
  assign bus.digit_1000  = dig_q[3];
  assign bus.dp          = dp_q;
  assign bus.value       = value_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.active      = active_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.bcd_err     = bcd_err_q;
endmodule
